// File: rtl/wash_pkg.sv
// Shared types for the wash sequencer: state encoding, the output bundle,
// and the Moore output decode used by the top level.
package wash_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FILL_SOAP   = 4'd1,
        SOAP_WASH   = 4'd2,
        DRAIN_SOAP  = 4'd3,
        FILL_RINSE  = 4'd4,
        RINSE       = 4'd5,
        DRAIN_RINSE = 4'd6,
        SPIN        = 4'd7,
        DONE        = 4'd8,
        FAULT       = 4'd9
    } state_e;

    typedef struct packed {
        logic door_lock;
        logic motor_on;
        logic fill_valve_on;
        logic drain_valve_on;
        logic soap_wash;
        logic water_wash;
        logic done;
        logic error;
    } outs_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Only pause and drained reach the outputs combinationally; pause gates
    // motor/fill, drained releases the lock once a faulted tub is empty.
    function automatic outs_t decode_outs(input state_e st, input logic pause,
                                          input logic drained);
        outs_t o;
        o = '0;
        o.door_lock = 1'b1;
        case (st)
            IDLE:        o.door_lock = 1'b0;
            FILL_SOAP:   o.fill_valve_on = !pause;
            SOAP_WASH: begin
                o.motor_on  = !pause;
                o.soap_wash = 1'b1;
            end
            DRAIN_SOAP:  o.drain_valve_on = 1'b1;
            FILL_RINSE:  o.fill_valve_on = !pause;
            RINSE: begin
                o.motor_on   = !pause;
                o.water_wash = 1'b1;
            end
            DRAIN_RINSE: o.drain_valve_on = 1'b1;
            SPIN: begin
                o.motor_on       = !pause;
                o.drain_valve_on = 1'b1;
            end
            DONE: begin
                o.door_lock = 1'b0;
                o.done      = 1'b1;
            end
            FAULT: begin
                o.error          = 1'b1;
                o.drain_valve_on = 1'b1;
                o.door_lock      = !drained;
            end
            default:     o.door_lock = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/wash_timer.sv
// Up-counter shared by every timed and fill state; clear wins over enable,
// terminal count flags the last counted cycle of the current state.
module wash_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)       cnt_q <= '0;
        else if (clr_i)  cnt_q <= '0;
        else if (en_i)   cnt_q <= cnt_q + 1'b1;
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/wash_cycle_controller.sv
// Washing-machine sequencer: soap wash, RINSE_COUNT fill/rinse/drain passes,
// spin, with pause and a fill-timeout fault that only reset clears.
module wash_cycle_controller
    import wash_pkg::*;
#(
    parameter int WASH_CYCLES  = 8,
    parameter int RINSE_CYCLES = 4,
    parameter int RINSE_COUNT  = 2,
    parameter int SPIN_CYCLES  = 6,
    parameter int FILL_LIMIT   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       door_close,
    input  logic       filled,
    input  logic       detergent_added,
    input  logic       drained,
    input  logic       pause,
    output logic       door_lock,
    output logic       motor_on,
    output logic       fill_valve_on,
    output logic       drain_valve_on,
    output logic       soap_wash,
    output logic       water_wash,
    output logic       done,
    output logic       error,
    output logic [3:0] state
);

    localparam int MAXC = max2(max2(WASH_CYCLES, RINSE_CYCLES), max2(SPIN_CYCLES, FILL_LIMIT));
    localparam int TW   = $clog2(MAXC + 1);
    localparam int RW   = $clog2(RINSE_COUNT + 1);

    // Terminal counts are N-1: the edge ending the Nth unpaused cycle exits.
    localparam logic [TW-1:0] WASH_TC  = TW'(WASH_CYCLES - 1);
    localparam logic [TW-1:0] RINSE_TC = TW'(RINSE_CYCLES - 1);
    localparam logic [TW-1:0] SPIN_TC  = TW'(SPIN_CYCLES - 1);
    localparam logic [TW-1:0] FILL_TC  = TW'(FILL_LIMIT - 1);
    localparam logic [RW-1:0] RINSE_LAST = RW'(RINSE_COUNT - 1);

    state_e          state_q, state_d;
    logic [RW-1:0]   rinse_q, rinse_d;
    logic [TW-1:0]   tmr_term;
    logic            tmr_en, tmr_clr, tmr_tc;
    outs_t           outs;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rinse_q <= '0;
        end else begin
            state_q <= state_d;
            rinse_q <= rinse_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rinse_d  = rinse_q;
        tmr_term = WASH_TC;
        tmr_en   = 1'b0;
        case (state_q)
            IDLE: if (start && door_close) state_d = FILL_SOAP;
            FILL_SOAP: begin
                tmr_term = FILL_TC;
                tmr_en   = !pause;
                // A fill completing on the timeout edge takes priority.
                if (!pause) begin
                    if (filled && detergent_added) state_d = SOAP_WASH;
                    else if (tmr_tc)               state_d = FAULT;
                end
            end
            SOAP_WASH: begin
                tmr_term = WASH_TC;
                tmr_en   = !pause;
                if (!pause && tmr_tc) state_d = DRAIN_SOAP;
            end
            DRAIN_SOAP: if (drained) begin
                state_d = FILL_RINSE;
                rinse_d = '0;
            end
            FILL_RINSE: begin
                tmr_term = FILL_TC;
                tmr_en   = !pause;
                if (!pause) begin
                    if (filled)      state_d = RINSE;
                    else if (tmr_tc) state_d = FAULT;
                end
            end
            RINSE: begin
                tmr_term = RINSE_TC;
                tmr_en   = !pause;
                if (!pause && tmr_tc) state_d = DRAIN_RINSE;
            end
            DRAIN_RINSE: if (drained) begin
                if (rinse_q == RINSE_LAST) begin
                    state_d = SPIN;
                end else begin
                    state_d = FILL_RINSE;
                    rinse_d = rinse_q + 1'b1;
                end
            end
            SPIN: begin
                tmr_term = SPIN_TC;
                tmr_en   = !pause;
                if (!pause && tmr_tc) state_d = DONE;
            end
            DONE:    if (!start) state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // Every state change restarts the shared timer.
    assign tmr_clr = (state_d != state_q);

    wash_timer #(.WIDTH(TW)) u_timer (
        .clk_i  (clock),
        .rst_i  (reset),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .term_i (tmr_term),
        .tc_o   (tmr_tc)
    );

    assign outs           = decode_outs(state_q, pause, drained);
    assign door_lock      = outs.door_lock;
    assign motor_on       = outs.motor_on;
    assign fill_valve_on  = outs.fill_valve_on;
    assign drain_valve_on = outs.drain_valve_on;
    assign soap_wash      = outs.soap_wash;
    assign water_wash     = outs.water_wash;
    assign done           = outs.done;
    assign error          = outs.error;
    assign state          = state_q;

endmodule
